commit_trace_buffer: RTL and testbench
======================================

// Module: commit_trace_buffer
// PURPOSE
// Synthesizable, parametrised commit-trace capture unit that sits beside the commit stage.
// Each cycle it takes retire events from NrCommitPorts commit ports plus one exception
// event, stamps each with a cycle timestamp and packs them into a multi-write FIFO.
// A valid/ready stream drains the FIFO one record per cycle, towards a DMA, debug
// module or bench sink. Overflow is never silent: it is counted and reported in-band.
// PARAMETERS
// NrCommitPorts  2    number of commit ports sampled per cycle (1..4)
// Depth          16   FIFO entries; power of 2, >= NrCommitPorts+2
// TsWidth        32   timestamp counter width; wraps modulo 2^TsWidth
// PORTS
// clk_i            in   1                  clock
// rst_ni           in   1                  asynchronous active-low reset
// trace_en_i       in   1                  capture enable; when low, pushes and drop counting stop
// commit_valid_i   in   NrCommitPorts      per-port retire strobe
// commit_pc_i      in   NrCommitPorts*VLEN per-port PC
// commit_instr_i   in   NrCommitPorts*32   per-port raw instruction word
// commit_rd_i      in   NrCommitPorts*5    destination register
// commit_we_i      in   NrCommitPorts      destination written (GPR or FPR)
// commit_fpr_i     in   NrCommitPorts      destination is FP register file
// commit_wdata_i   in   NrCommitPorts*64   write-back data
// priv_lvl_i       in   2                  current privilege level (riscv::priv_lvl_t)
// ex_valid_i       in   1                  exception taken this cycle
// ex_cause_i       in   64                 exception cause
// ex_tval_i        in   64                 exception tval
// rec_valid_o      out  1                  output record valid
// rec_ready_i      in   1                  sink ready
// rec_o            out  $bits(trace_rec_t) output record
// drop_cnt_o       out  32                 total records lost; saturates at 2^32-1
// usage_o          out  $clog2(Depth)+1    current FIFO occupancy
// BEHAVIOUR
// - Reset (async, rst_ni=0): FIFO empty, rec_valid_o=0, rec_o='0, drop_cnt_o=0, usage_o=0,
//   timestamp=0, pending-loss counter=0, marker flag clear. Reset mid-stream discards all contents.
// - Timestamp: increments every cycle after reset, independent of trace_en_i; wraps to 0.
// - Demand: N = popcount(commit_valid_i) + ex_valid_i, counted only when trace_en_i=1.
//   Records are ordered port 0..NrCommitPorts-1, then the exception (kind EXC, pc=port-0 PC,
//   wdata=cause, instr=tval[31:0]). Commit records are kind COMMIT.
// - Free space = Depth - usage at start of cycle; a same-cycle pop is NOT credited.
// - All-or-nothing: if the marker flag is clear and free >= N, push all N records.
//   Otherwise push none: pending-loss += N and drop_cnt_o += N (both saturating); set marker flag.
// - Marker: while the marker flag is set, the next push needs free >= N+1 and first writes
//   kind DROP with wdata = pending-loss, then the N records. Pending-loss and the flag then clear.
//   If no event arrives, the marker is pushed alone as soon as free >= 1.
// - Output: a record written in cycle t is visible on rec_o no earlier than t+1 (registered).
//   A pop occurs on rec_valid_o & rec_ready_i. rec_o is held stable while valid & !ready.
// - Simultaneous push and pop are allowed; usage updates by +pushed-popped.
//   Pointers wrap modulo Depth.
// - trace_en_i=0: no pushes, no drop counting; a pending marker stays pending; the FIFO keeps draining.
// STRUCTURE
// - trace_pkg:
//   - trace_kind_e {COMMIT, EXC, DROP}
//   - trace_rec_t {kind, priv, fpr, we, rd, pc, instr, wdata, ts}
//   - default constants
// - Sub-module trace_mwfifo: up to NrCommitPorts+2 writes per cycle, single read port,
//   occupancy output.
// - Top-level logic: demand popcount, space check, marker FSM (IDLE/LOSS), timestamp, drop counters.
// TESTING
// 1 Reset: hold rst_ni=0, drive commits -> rec_valid_o=0, usage_o=0, drop_cnt_o=0.
// 2 Dual commit: ports 0,1 valid, pc 0x80000000/0x80000004 -> two COMMIT records, in port order,
//   equal ts, from cycle t+1.
// 3 Overflow, Depth=16:
//   - With rec_ready_i=0, 9 cycles of 2 commits -> usage 16; 9th cycle dropped, drop_cnt_o=2.
//   - Then ready=1 -> 16 records, then DROP wdata=2, then new commits.
// 4 Exception with commit: port0 commit + ex_valid_i, cause 0x2 -> COMMIT then EXC wdata=0x2.
// 5 Backpressure: toggle rec_ready_i every cycle -> rec_o stable while stalled; no loss or duplicates.
// 6 Disable and async reset mid-stream:
//   - trace_en_i=0 with commits -> usage unchanged, drop_cnt_o unchanged.
//   - rst_ni pulsed while usage=5 -> usage_o=0 immediately.

Source files
------------

// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace buffer: record layout, record kinds, defaults.
// No logic with latency; the package only holds types, constants and one helper.
// No flow control here; see commit_trace_buffer for the stream behaviour.
package commit_trace_buffer_pkg;

    localparam int unsigned Vlen             = 64;
    localparam int unsigned TsRecW           = 64;
    localparam int unsigned DefNrCommitPorts = 2;
    localparam int unsigned DefDepth         = 16;
    localparam int unsigned DefTsWidth       = 32;

    typedef enum logic [1:0] {
        COMMIT = 2'd0,
        EXC    = 2'd1,
        DROP   = 2'd2
    } trace_kind_e;

    typedef struct packed {
        trace_kind_e       kind;
        logic [1:0]        priv;
        logic              fpr;
        logic              we;
        logic [4:0]        rd;
        logic [Vlen-1:0]   pc;
        logic [31:0]       instr;
        logic [63:0]       wdata;
        logic [TsRecW-1:0] ts;
    } trace_rec_t;

    // 32-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Trace record stream: rec_valid/rec_ready handshake carrying one trace_rec_t.
// No latency of its own; a transfer happens on rec_valid & rec_ready.
// Master holds rec stable while rec_valid & !rec_ready.
interface commit_trace_buffer_if;

    logic                                rec_valid;
    logic                                rec_ready;
    commit_trace_buffer_pkg::trace_rec_t rec;

    modport master (output rec_valid, output rec, input rec_ready);
    modport slave  (input rec_valid, input rec, output rec_ready);

endinterface

// File: rtl/commit_trace_buffer_mwfifo.sv
// Multi-write, single-read FIFO of trace records; wr_cnt_i entries are taken from wr_dat_i[0..].
// Write in cycle t is readable from t+1; rd_dat_o is the head entry (zero when empty).
// Writer must never exceed free space; pop_i is ignored when empty. Ports: writes, pop, head, usage.
module commit_trace_buffer_mwfifo
    import commit_trace_buffer_pkg::*;
#(
    parameter int unsigned Depth = 16,
    parameter int unsigned NrWr  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [$clog2(NrWr+1)-1:0]  wr_cnt_i,
    input  trace_rec_t                 wr_dat_i [NrWr],
    input  logic                       pop_i,
    output trace_rec_t                 rd_dat_o,
    output logic                       rd_vld_o,
    output logic [$clog2(Depth):0]     usage_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned UsW  = $clog2(Depth) + 1;

    trace_rec_t      mem [Depth];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [UsW-1:0]  cnt_q;
    logic            pop;

    assign rd_vld_o = (cnt_q != '0);
    assign pop      = pop_i & rd_vld_o;
    // Gate the head so the stream reads as zero whenever nothing is valid.
    assign rd_dat_o = rd_vld_o ? mem[rd_ptr_q] : '0;
    assign usage_o  = cnt_q;

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NrWr; i++) begin
            if (i < int'(wr_cnt_i)) begin
                mem[wr_ptr_q + PtrW'(i)] <= wr_dat_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PtrW'(wr_cnt_i);
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            cnt_q <= cnt_q + UsW'(wr_cnt_i) - UsW'(pop);
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace capture: timestamps commit/exception events and packs them into a FIFO.
// Events seen in cycle t appear on rec_if from t+1; one record drains per handshake.
// Lack of space drops a whole cycle's events, counted, and announced later by a DROP record.
// Ports: clk_i/rst_ni, trace_en_i, per-port commit buses, priv/exception, rec_if, drop_cnt_o, usage_o.
module commit_trace_buffer
    import commit_trace_buffer_pkg::*;
#(
    parameter int unsigned NrCommitPorts = DefNrCommitPorts,
    parameter int unsigned Depth         = DefDepth,
    parameter int unsigned TsWidth       = DefTsWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          trace_en_i,
    input  logic [NrCommitPorts-1:0]      commit_valid_i,
    input  logic [NrCommitPorts*Vlen-1:0] commit_pc_i,
    input  logic [NrCommitPorts*32-1:0]   commit_instr_i,
    input  logic [NrCommitPorts*5-1:0]    commit_rd_i,
    input  logic [NrCommitPorts-1:0]      commit_we_i,
    input  logic [NrCommitPorts-1:0]      commit_fpr_i,
    input  logic [NrCommitPorts*64-1:0]   commit_wdata_i,
    input  logic [1:0]                    priv_lvl_i,
    input  logic                          ex_valid_i,
    input  logic [63:0]                   ex_cause_i,
    input  logic [63:0]                   ex_tval_i,
    commit_trace_buffer_if.master         rec_if,
    output logic [31:0]                   drop_cnt_o,
    output logic [$clog2(Depth):0]        usage_o
);

    localparam int unsigned NrEv  = NrCommitPorts + 1;
    localparam int unsigned NrWr  = NrCommitPorts + 2;
    localparam int unsigned WcW   = $clog2(NrWr + 1);
    localparam int unsigned SlotW = $clog2(NrWr);

    // LOSS means records were lost and a DROP marker is still owed.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOSS = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [TsWidth-1:0] ts_q;
    logic [31:0]        pend_q, pend_d;
    logic [31:0]        drop_q, drop_d;
    logic [31:0]        demand, need, free_cnt;
    logic               push_ok;
    logic [NrEv-1:0]    ev_vld;
    trace_rec_t         ev_rec [NrEv];
    trace_rec_t         wr_dat [NrWr];
    logic [WcW-1:0]     wr_cnt;
    logic [SlotW-1:0]   slot;
    trace_rec_t         head_rec;
    logic               head_vld;
    logic               unused_tval;

    assign unused_tval = ^ex_tval_i[63:32];

    // Candidate events in record order: ports 0..N-1, then the exception.
    always_comb begin
        for (int p = 0; p < NrCommitPorts; p++) begin
            ev_vld[p]       = trace_en_i & commit_valid_i[p];
            ev_rec[p]       = '0;
            ev_rec[p].kind  = COMMIT;
            ev_rec[p].priv  = priv_lvl_i;
            ev_rec[p].fpr   = commit_fpr_i[p];
            ev_rec[p].we    = commit_we_i[p];
            ev_rec[p].rd    = commit_rd_i[p*5 +: 5];
            ev_rec[p].pc    = commit_pc_i[p*Vlen +: Vlen];
            ev_rec[p].instr = commit_instr_i[p*32 +: 32];
            ev_rec[p].wdata = commit_wdata_i[p*64 +: 64];
            ev_rec[p].ts    = TsRecW'(ts_q);
        end
        ev_vld[NrCommitPorts]       = trace_en_i & ex_valid_i;
        ev_rec[NrCommitPorts]       = '0;
        ev_rec[NrCommitPorts].kind  = EXC;
        ev_rec[NrCommitPorts].priv  = priv_lvl_i;
        ev_rec[NrCommitPorts].pc    = commit_pc_i[Vlen-1:0];
        ev_rec[NrCommitPorts].instr = ex_tval_i[31:0];
        ev_rec[NrCommitPorts].wdata = ex_cause_i;
        ev_rec[NrCommitPorts].ts    = TsRecW'(ts_q);
    end

    // Space check and loss accounting. Free space ignores a same-cycle pop.
    always_comb begin
        demand = '0;
        for (int e = 0; e < NrEv; e++) begin
            demand = demand + 32'(ev_vld[e]);
        end
        free_cnt = 32'(Depth) - 32'(usage_o);
        // An owed marker costs one extra slot; with no events it goes out alone.
        need     = demand + 32'(state_q == ST_LOSS);
        push_ok  = trace_en_i && (need != '0) && (free_cnt >= need);

        state_d = state_q;
        pend_d  = pend_q;
        drop_d  = drop_q;
        if (push_ok) begin
            state_d = ST_IDLE;
            pend_d  = '0;
        end else if (demand != '0) begin
            state_d = ST_LOSS;
            pend_d  = sat_add32(pend_q, demand);
            drop_d  = sat_add32(drop_q, demand);
        end
    end

    // Compact marker + valid events into consecutive write slots.
    always_comb begin
        for (int i = 0; i < NrWr; i++) begin
            wr_dat[i] = '0;
        end
        slot = '0;
        if (state_q == ST_LOSS) begin
            wr_dat[0]       = '0;
            wr_dat[0].kind  = DROP;
            wr_dat[0].priv  = priv_lvl_i;
            wr_dat[0].wdata = 64'(pend_q);
            wr_dat[0].ts    = TsRecW'(ts_q);
            slot            = SlotW'(1);
        end
        for (int e = 0; e < NrEv; e++) begin
            if (ev_vld[e]) begin
                wr_dat[slot] = ev_rec[e];
                slot         = slot + SlotW'(1);
            end
        end
        wr_cnt = push_ok ? WcW'(need) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ts_q    <= '0;
            pend_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + TsWidth'(1);
            pend_q  <= pend_d;
            drop_q  <= drop_d;
        end
    end

    commit_trace_buffer_mwfifo #(
        .Depth (Depth),
        .NrWr  (NrWr)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wr_cnt_i (wr_cnt),
        .wr_dat_i (wr_dat),
        .pop_i    (head_vld & rec_if.rec_ready),
        .rd_dat_o (head_rec),
        .rd_vld_o (head_vld),
        .usage_o  (usage_o)
    );

    assign rec_if.rec_valid = head_vld;
    assign rec_if.rec       = head_rec;
    assign drop_cnt_o       = drop_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer (2 ports, depth 16).
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
// Sink readiness is driven directly through the record interface.
module tb_commit_trace_buffer;
    import commit_trace_buffer_pkg::*;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b1;
    logic         trace_en = 1'b1;
    logic [1:0]   cv = '0;
    logic [127:0] cpc = '0;
    logic [63:0]  cinstr = '0;
    logic [9:0]   crd = '0;
    logic [1:0]   cwe = '0;
    logic [1:0]   cfpr = '0;
    logic [127:0] cwd = '0;
    logic [1:0]   priv = 2'd3;
    logic         ex_v = 1'b0;
    logic [63:0]  cause = '0;
    logic [63:0]  tval = '0;
    logic [31:0]  drop_cnt;
    logic [4:0]   usage;

    int checks = 0;
    int failures = 0;

    commit_trace_buffer_if rec_if();

    commit_trace_buffer #(
        .NrCommitPorts (2),
        .Depth         (16),
        .TsWidth       (32)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .trace_en_i     (trace_en),
        .commit_valid_i (cv),
        .commit_pc_i    (cpc),
        .commit_instr_i (cinstr),
        .commit_rd_i    (crd),
        .commit_we_i    (cwe),
        .commit_fpr_i   (cfpr),
        .commit_wdata_i (cwd),
        .priv_lvl_i     (priv),
        .ex_valid_i     (ex_v),
        .ex_cause_i     (cause),
        .ex_tval_i      (tval),
        .rec_if         (rec_if),
        .drop_cnt_o     (drop_cnt),
        .usage_o        (usage)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_commit(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1);
        cv  = v;
        cpc = {pc1, pc0};
    endtask

    initial begin
        logic [63:0] ts0;
        int          k;
        logic        pop_now;

        rec_if.rec_ready = 1'b0;
        #1 rst_ni = 1'b0;

        // 1: reset held with commits driven
        set_commit(2'b11, 64'h100, 64'h104);
        repeat (3) step();
        chk("rst_valid", 64'(rec_if.rec_valid), 64'd0);
        chk("rst_usage", 64'(usage), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_rec_pc", rec_if.rec.pc, 64'd0);
        rst_ni = 1'b1;
        set_commit(2'b00, 64'h0, 64'h0);
        step();

        // 2: dual commit in port order, same timestamp
        set_commit(2'b11, 64'h8000_0000, 64'h8000_0004);
        crd    = {5'd7, 5'd5};
        cwe    = 2'b01;
        cfpr   = 2'b10;
        cwd    = {64'h22, 64'h11};
        chk("dual_not_early", 64'(rec_if.rec_valid), 64'd0);
        step();
        set_commit(2'b00, 64'h0, 64'h0);
        chk("dual_usage", 64'(usage), 64'd2);
        chk("dual_valid", 64'(rec_if.rec_valid), 64'd1);
        chk("dual_kind0", 64'(rec_if.rec.kind), 64'(COMMIT));
        chk("dual_pc0", rec_if.rec.pc, 64'h8000_0000);
        chk("dual_rd0", 64'(rec_if.rec.rd), 64'd5);
        chk("dual_wd0", rec_if.rec.wdata, 64'h11);
        ts0 = rec_if.rec.ts;
        rec_if.rec_ready = 1'b1;
        step();
        chk("dual_pc1", rec_if.rec.pc, 64'h8000_0004);
        chk("dual_fpr1", 64'(rec_if.rec.fpr), 64'd1);
        chk("dual_ts_eq", rec_if.rec.ts, ts0);
        step();
        chk("dual_empty", 64'(rec_if.rec_valid), 64'd0);
        rec_if.rec_ready = 1'b0;

        // 3: overflow with sink stalled, then drain and marker
        for (int c = 0; c < 9; c++) begin
            set_commit(2'b11, 64'h1000 + 64'(8 * c), 64'h1004 + 64'(8 * c));
            step();
            if (c == 7) begin
                chk("ovf_full", 64'(usage), 64'd16);
                chk("ovf_nodrop_yet", 64'(drop_cnt), 64'd0);
            end
        end
        set_commit(2'b00, 64'h0, 64'h0);
        chk("ovf_usage", 64'(usage), 64'd16);
        chk("ovf_drop", 64'(drop_cnt), 64'd2);
        rec_if.rec_ready = 1'b1;
        for (int r = 0; r < 16; r++) begin
            chk("ovf_drain_kind", 64'(rec_if.rec.kind), 64'(COMMIT));
            chk("ovf_drain_pc", rec_if.rec.pc, 64'h1000 + 64'(4 * r));
            step();
        end
        chk("ovf_marker_valid", 64'(rec_if.rec_valid), 64'd1);
        chk("ovf_marker_kind", 64'(rec_if.rec.kind), 64'(DROP));
        chk("ovf_marker_wdata", rec_if.rec.wdata, 64'd2);
        set_commit(2'b01, 64'h2000, 64'h0);
        step();
        set_commit(2'b00, 64'h0, 64'h0);
        chk("ovf_new_kind", 64'(rec_if.rec.kind), 64'(COMMIT));
        chk("ovf_new_pc", rec_if.rec.pc, 64'h2000);
        chk("ovf_drop_hold", 64'(drop_cnt), 64'd2);
        step();
        chk("ovf_empty", 64'(usage), 64'd0);
        rec_if.rec_ready = 1'b0;

        // 4: exception with a port-0 commit
        set_commit(2'b01, 64'h3000, 64'h0);
        ex_v  = 1'b1;
        cause = 64'h2;
        tval  = 64'hDEAD_BEEF_1234_5678;
        step();
        set_commit(2'b00, 64'h0, 64'h0);
        ex_v = 1'b0;
        chk("exc_usage", 64'(usage), 64'd2);
        chk("exc_first_kind", 64'(rec_if.rec.kind), 64'(COMMIT));
        rec_if.rec_ready = 1'b1;
        step();
        chk("exc_kind", 64'(rec_if.rec.kind), 64'(EXC));
        chk("exc_wdata", rec_if.rec.wdata, 64'h2);
        chk("exc_pc", rec_if.rec.pc, 64'h3000);
        chk("exc_instr", 64'(rec_if.rec.instr), 64'h1234_5678);
        step();
        chk("exc_empty", 64'(rec_if.rec_valid), 64'd0);
        rec_if.rec_ready = 1'b0;

        // 5: toggling backpressure, six records
        for (int c = 0; c < 3; c++) begin
            set_commit(2'b11, 64'h4000 + 64'(8 * c), 64'h4004 + 64'(8 * c));
            step();
        end
        set_commit(2'b00, 64'h0, 64'h0);
        k = 0;
        for (int c = 0; c < 30 && k < 6; c++) begin
            rec_if.rec_ready = c[0];
            if (rec_if.rec_valid) begin
                chk("bp_pc", rec_if.rec.pc, 64'h4000 + 64'(4 * k));
            end
            pop_now = rec_if.rec_valid & rec_if.rec_ready;
            step();
            if (pop_now) k++;
        end
        chk("bp_count", 64'(k), 64'd6);
        chk("bp_empty", 64'(usage), 64'd0);
        chk("bp_drop", 64'(drop_cnt), 64'd2);
        rec_if.rec_ready = 1'b0;

        // 6: disable, then async reset mid-stream
        set_commit(2'b11, 64'h6000, 64'h6004);
        step();
        step();
        set_commit(2'b01, 64'h6010, 64'h0);
        step();
        chk("dis_fill", 64'(usage), 64'd5);
        trace_en = 1'b0;
        set_commit(2'b11, 64'h7000, 64'h7004);
        ex_v = 1'b1;
        repeat (3) step();
        chk("dis_usage", 64'(usage), 64'd5);
        chk("dis_drop", 64'(drop_cnt), 64'd2);
        trace_en = 1'b1;
        ex_v     = 1'b0;
        set_commit(2'b00, 64'h0, 64'h0);
        rst_ni = 1'b0;
        #1;
        chk("arst_usage", 64'(usage), 64'd0);
        chk("arst_valid", 64'(rec_if.rec_valid), 64'd0);
        chk("arst_drop", 64'(drop_cnt), 64'd0);
        #1 rst_ni = 1'b1;
        set_commit(2'b01, 64'h5000, 64'h0);
        step();
        set_commit(2'b00, 64'h0, 64'h0);
        chk("post_rst_usage", 64'(usage), 64'd1);
        chk("post_rst_pc", rec_if.rec.pc, 64'h5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
